// File: rtl/deserializer.sv
// Serial-to-parallel receiver, MSB first, with a held output word and a valid/ack handshake.
// Optional sticky overrun detection is built only when DESERIALIZER_OVERRUN_EN is defined.
module deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_bit,
  input  logic             in_enable,
  input  logic             in_clear,
  input  logic             in_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_busy,
  output logic             out_overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] word_next;
  logic             shift;
  logic             complete;

  // A clear suppresses the shift, and with it any completion in that cycle.
  assign shift     = in_enable & ~in_clear;
  assign complete  = shift & (cnt_reg == LAST_CNT);
  assign word_next = {shreg_reg[WIDTH-2:0], in_bit};

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_clear) begin
        shreg_reg <= '0;
        cnt_reg   <= '0;
      end else if (in_enable) begin
        shreg_reg <= word_next;
        cnt_reg   <= complete ? '0 : cnt_reg + 1'b1;
      end
      if (complete) begin
        out_data  <= word_next;
        out_valid <= 1'b1;
      end else if (in_ack) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_busy = (cnt_reg != '0);

`ifdef DESERIALIZER_OVERRUN_EN
  logic overrun_reg;

  always_ff @(posedge in_clock) begin
    if (in_reset || in_clear) begin
      overrun_reg <= 1'b0;
    end else if (complete && out_valid && !in_ack) begin
      overrun_reg <= 1'b1;
    end
  end

  assign out_overrun = overrun_reg;
`else
  assign out_overrun = 1'b0;
`endif

endmodule
